// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access size codes,
// byte-offset width derivation and split-access state encoding.
package data_mem_ctrl_pkg;

  // Access size codes carried in data_mem_we[1:0]
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Split-access sequencer states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  // Number of byte-offset bits within one XLEN word
  function automatic int unsigned ofs_of(input int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_bank_ram.sv
// Byte-lane word RAM: one write port with per-byte enables and one
// synchronous read port whose output holds between reads. No reset.
//   clk   : clock
//   addr  : word index shared by write and read
//   be    : per-byte write enables
//   wdata : lane-positioned write data
//   re    : read enable; rdata updates only when set
//   rdata : registered read word
module dmem_bank_ram #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 10
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN/8-1:0] be,
  input  logic [XLEN-1:0]   wdata,
  input  logic              re,
  output logic [XLEN-1:0]   rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic [XLEN-1:0] mem [DEPTH];

  // Byte-masked write and registered read
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the MemoryAccess stage. Handles byte/half/word
// (and double on XLEN=64) loads and stores with 1-cycle read latency and a
// two-beat sequence for accesses that straddle a word boundary.
//   clk, rst_n     : clock, async active-low reset
//   data_mem_addr  : byte address
//   data_mem_wdata : store data, LSB-aligned
//   data_mem_we    : [2] write request, [1:0] access size
//   data_mem_re    : read request
//   data_mem_out   : load data, LSB-aligned, zero above the access size
//   data_mem_busy  : second beat of a split access in progress
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] data_mem_addr,
  input  logic [XLEN-1:0]   data_mem_wdata,
  input  logic [2:0]        data_mem_we,
  input  logic              data_mem_re,
  output logic [XLEN-1:0]   data_mem_out,
  output logic              data_mem_busy
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OFS = ofs_of(XLEN);
  localparam int unsigned WW  = AWIDTH - OFS;

  state_t state_q, state_d;

  logic [AWIDTH-1:0] lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic [1:0]        lat_size;
  logic              lat_wr, lat_rd;
  logic              rd_fresh, sp_fresh;
  logic [XLEN-1:0]   beat1_q, out_hold;
  logic              busy_q;

  logic [WW-1:0]     ram_addr;
  logic [NB-1:0]     ram_be;
  logic [XLEN-1:0]   ram_wdata, ram_rdata;
  logic              ram_re;

  logic              wr_req, rd_req, accept;
  int unsigned       in_nb, in_off;
  int unsigned       l_nb, l_off, l_k;
  logic              in_split;

  // Lanes lo..hi-1, clipped to the word
  function automatic logic [NB-1:0] lane_mask(input int unsigned lo, input int unsigned hi);
    logic [NB-1:0] m;
    for (int unsigned b = 0; b < NB; b++) m[b] = (b >= lo) && (b < hi);
    return m;
  endfunction

  // Zero every byte at or above byte n
  function automatic logic [XLEN-1:0] keep_bytes(input logic [XLEN-1:0] v, input int unsigned n);
    logic [XLEN-1:0] r;
    r = v;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b >= n) r[8*b +: 8] = 8'h00;
    end
    return r;
  endfunction

  dmem_bank_ram #(.XLEN(XLEN), .AW(WW)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  // Request decode, RAM port steering and next state
  always_comb begin
    in_nb    = 32'd1 << data_mem_we[1:0];
    in_off   = 32'(data_mem_addr[OFS-1:0]);
    in_split = (in_off + in_nb) > NB;
    l_nb     = 32'd1 << lat_size;
    l_off    = 32'(lat_addr[OFS-1:0]);
    l_k      = NB - l_off;

    wr_req = data_mem_we[2];
    rd_req = data_mem_re & ~data_mem_we[2];   // write wins when both are set
    accept = (state_q == ST_IDLE) & (data_mem_we[2] | data_mem_re);

    state_d   = state_q;
    ram_addr  = data_mem_addr[AWIDTH-1:OFS];
    ram_wdata = data_mem_wdata << (8 * in_off);
    ram_be    = '0;
    ram_re    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (wr_req) ram_be = lane_mask(in_off, in_off + in_nb);
          ram_re = rd_req;
          if (in_split) state_d = ST_SECOND;
        end
      end
      ST_SECOND: begin
        // Next word (wrapping), low lanes, remaining upper bytes of the store
        ram_addr  = lat_addr[AWIDTH-1:OFS] + WW'(1);
        ram_wdata = lat_wdata >> (8 * l_k);
        if (lat_wr) ram_be = lane_mask(0, l_nb - l_k);
        ram_re  = lat_rd;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output selects the freshly completed load, otherwise holds the last one
  always_comb begin
    if (rd_fresh)
      data_mem_out = keep_bytes(ram_rdata >> (8 * l_off), l_nb);
    else if (sp_fresh)
      data_mem_out = keep_bytes(beat1_q | (ram_rdata << (8 * l_k)), l_nb);
    else
      data_mem_out = out_hold;
  end

  assign data_mem_busy = busy_q;

  // State, request latch, beat-1 capture and output hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= SZ_B;
      lat_wr    <= 1'b0;
      lat_rd    <= 1'b0;
      rd_fresh  <= 1'b0;
      sp_fresh  <= 1'b0;
      beat1_q   <= '0;
      out_hold  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d == ST_SECOND);
      rd_fresh <= accept & rd_req & ~in_split;
      sp_fresh <= (state_q == ST_SECOND) & lat_rd;
      out_hold <= data_mem_out;
      if (accept) begin
        lat_addr  <= data_mem_addr;
        lat_wdata <= data_mem_wdata;
        lat_size  <= data_mem_we[1:0];
        lat_wr    <= wr_req;
        lat_rd    <= rd_req;
      end
      // Top k bytes of the first word, moved down to the LSBs
      if ((state_q == ST_SECOND) && lat_rd) beat1_q <= ram_rdata >> (8 * l_off);
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Responder on the data-memory interface driven by the MemoryAccess stage: accepts address, write data, write-enable and size, and returns load data on data_mem_out.
- Owns a byte-lane synchronous RAM and reads with 1-cycle latency.
- Handles accesses that cross a word boundary with a two-beat state machine.
- Raises data_mem_busy so the stage can feed it into its stall output.

Parameters:
- XLEN, 32, data width in bits; 32 or 64 supported.
- AWIDTH, 12, byte-address width; RAM depth is 2^(AWIDTH-OFS) words, where OFS = log2(XLEN/8).

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- data_mem_addr  in  AWIDTH  byte address
- data_mem_wdata  in  XLEN  store data, LSB-aligned
- data_mem_we  in  3  bit2 = write request; bits1:0 = size (0=B, 1=H, 2=W, 3=D), valid for reads and writes
- data_mem_re  in  1  read request
- data_mem_out  out  XLEN  load data, LSB-aligned, registered
- data_mem_busy  out  1  second beat of a split access in progress; requester must hold its inputs

Behaviour:
- Reset: asynchronous and active-low. data_mem_out=0, data_mem_busy=0, state=IDLE. RAM contents are not initialised.
- Request condition: req = data_mem_we[2] | data_mem_re, accepted only in IDLE. If both are set, the write wins and data_mem_out is unchanged.
- Field decode:
  - nbytes = 1 << size
  - off = addr[OFS-1:0]
  - widx = addr[AWIDTH-1:OFS]
  - split = (off + nbytes > XLEN/8)
  - Size D with XLEN=32 is illegal; the bench never drives it and the behaviour is unspecified.
- Aligned write: at the accepting posedge, write wdata[8*nbytes-1:0] into word widx at byte lanes off..off+nbytes-1. Other lanes are untouched. busy stays 0.
- Aligned read: the RAM word is read at the accepting posedge. data_mem_out is valid the next cycle and equals word >> (8*off), with bytes at and above nbytes forced to 0. The stage performs sign extension.
- Split access, state IDLE -> SECOND -> IDLE:
  - Beat 1 (accept cycle, IDLE): word widx, lanes off..XLEN/8-1. Store writes the low k = XLEN/8-off bytes of wdata; load captures the top k bytes of the word.
  - Beat 2 (SECOND): word (widx+1) mod depth, lanes 0..nbytes-k-1. Store writes the remaining upper wdata bytes.
  - Last-word wrap: a split at the top word wraps to word 0.
  - Addr, wdata and size are latched at accept, so beat 2 uses the latched values.
  - data_mem_busy=1 for exactly the SECOND cycle (registered, asserted the cycle after accept).
  - Load result appears on data_mem_out the cycle after SECOND: low k bytes from beat 1, then the beat-2 bytes, upper bytes zero.
  - Inputs are ignored while in SECOND.
- data_mem_out holds its value until the next read completes. Writes never change it.
- Reset mid-split: immediate return to IDLE with busy=0. A pending beat-2 write is dropped; the beat-1 bytes remain written.
- Back-to-back requests: an aligned request may be accepted every cycle. A read issued the cycle after a write to the same lanes returns the new data, because the write completes at the earlier posedge.

Decomposition:
- Size codes (SZ_B/H/W/D) go in the shared core_general.vh beside the FUNCT3 constants.
- The same header holds the OFS derivation and the state encoding (ST_IDLE, ST_SECOND).
- Sub-module dmem_bank_ram: one write port with per-byte enables, one synchronous read port, no reset.
- data_mem_ctrl holds the lane-mask and shift logic, the split FSM, the beat-1 capture register and the output register.

Test Plan (XLEN=32, AWIDTH=12):
1. Write 0x11223344 to 0x010 with size W; next cycle read 0x010 with size W -> the following cycle data_mem_out=0x11223344, busy never 1.
2. After test 1, byte write wdata=0x000000AB at 0x013 -> read W at 0x010 gives 0xAB223344; read B at 0x013 gives 0x000000AB; read H at 0x012 gives 0x0000AB22.
3. Split H write 0xBEEF at 0x017 -> busy high exactly 1 cycle; byte 0x017=0xEF, byte 0x018=0xBE. Then split H read at 0x017 -> busy for 1 cycle, data_mem_out=0x0000BEEF one cycle after busy falls.
4. Wrap: W write 0xCAFEF00D at 0xFFE -> word 0x3FF bytes 2,3 = 0D,F0 and word 0 bytes 0,1 = FE,CA. Split W read at 0xFFE returns 0xCAFEF00D.
5. Assert rst_n=0 during SECOND of a split W write of 0xCAFEF00D at 0x00E -> busy=0 and out=0 immediately. Word 3 bytes 2,3 = 0D,F0; word 4 is unchanged. Aligned read of 0x004 afterwards returns correct data.
6. we[2]=1 and re=1 in the same cycle (W 0x55AA55AA at 0x020), with data_mem_out previously 0x1234 -> memory word 8 = 0x55AA55AA, data_mem_out stays 0x1234.
